// File: rtl/sdram_chip_responder.sv
// SDR SDRAM chip-side responder: decodes controller commands into a small array.
// Optional tRCD/tRP checking is enabled by defining SDRAM_RESP_TIMING_CHECK_EN.
module sdram_chip_responder #(
  parameter int ROW_W = 4,
  parameter int COL_W = 4,
  parameter int TRCD  = 2,
  parameter int TRP   = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [11:0] sdram_addr,
  input  logic [1:0]  sdram_ba,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic        sdram_cke,
  input  logic [1:0]  sdram_dqm,
  inout  wire  [15:0] sdram_dq,
  output logic        proto_err,
  output logic [2:0]  err_code
);

  localparam int AW = 2 + ROW_W + COL_W;

  logic [15:0] mem [2**AW];

  logic [2:0] cmd;
  logic is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_bst;

  logic mode_ok, mode_cl3, mode_legal;
  logic [1:0] mode_bl;

  logic [3:0] bank_open, nxt_open;
  logic [ROW_W-1:0] bank_row [4];
  logic any_open, tgt_open, tmr_busy;

  logic [2:0] err;
  logic rw_go, act_go, lmr_go, pre_bank, cont;

  logic b_act, b_wr, b_ap;
  logic [1:0] b_ba;
  logic [COL_W-1:0] b_col;
  logic [2:0] b_k;

  logic [2:0] blm1;
  logic [COL_W-1:0] bmask;
  logic beat_en, beat_wr, beat_last, beat_ap, ap_close;
  logic [1:0] beat_ba;
  logic [COL_W-1:0] beat_col;
  logic [AW-1:0] beat_addr;

  logic s0_v, s1_v;
  logic [15:0] s0_d, s1_d, o_d;
  logic [1:0] o_oe, dqm_d;

  logic unused_ok;
  assign unused_ok = ^{sdram_addr, 32'(TRCD), 32'(TRP)};

  assign cmd = sdram_cs_n ? 3'b111
             : {sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign is_act = cmd == 3'b011;
  assign is_rd  = cmd == 3'b101;
  assign is_wr  = cmd == 3'b100;
  assign is_pre = cmd == 3'b010;
  assign is_ref = cmd == 3'b001;
  assign is_lmr = cmd == 3'b000;
  assign is_bst = cmd == 3'b110;

  assign mode_legal = (sdram_addr[6:4] == 3'd2 ||
                       sdram_addr[6:4] == 3'd3) &&
                      sdram_addr[3:2] == 2'b00;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
  logic [7:0] tmr [4];
  assign tmr_busy = tmr[sdram_ba] != 8'd0;
`else
  assign tmr_busy = 1'b0;
`endif

  always_comb begin
    err = 3'd0;
    unique case (1'b1)
      is_rd, is_wr: begin
        if (!mode_ok)       err = 3'd3;
        else if (!tgt_open) err = 3'd1;
        else if (tmr_busy)  err = 3'd6;
      end
      is_act: begin
        if (!mode_ok)      err = 3'd3;
        else if (tgt_open) err = 3'd2;
        else if (tmr_busy) err = 3'd6;
      end
      is_lmr: begin
        if (any_open)         err = 3'd4;
        else if (!mode_legal) err = 3'd5;
      end
      is_ref: begin
        if (any_open) err = 3'd4;
      end
      default: ;
    endcase
  end

  assign rw_go    = (is_rd | is_wr) & (err == 3'd0);
  assign act_go   = is_act & (err == 3'd0);
  assign lmr_go   = is_lmr & (err == 3'd0);
  assign pre_bank = is_pre & (sdram_addr[10] | (sdram_ba == b_ba));
  assign cont     = b_act & ~rw_go & ~is_bst & ~pre_bank;

  assign blm1  = 3'((4'd1 << mode_bl) - 4'd1);
  assign bmask = COL_W'(blm1);

  // Beat 0 comes straight from the command; later beats wrap inside the BL block.
  always_comb begin
    beat_en = rw_go | cont;
    if (rw_go) begin
      beat_wr   = is_wr;
      beat_ba   = sdram_ba;
      beat_col  = sdram_addr[COL_W-1:0];
      beat_last = blm1 == 3'd0;
      beat_ap   = sdram_addr[10];
    end else begin
      beat_wr   = b_wr;
      beat_ba   = b_ba;
      beat_col  = (b_col & ~bmask) |
                  ((b_col + COL_W'(b_k)) & bmask);
      beat_last = b_k == blm1;
      beat_ap   = b_ap;
    end
  end

  assign beat_addr = {beat_ba, bank_row[beat_ba], beat_col};
  assign ap_close  = beat_en & beat_last & beat_ap;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) bank_open <= '0;
    else if (sdram_cke) bank_open <= nxt_open;
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      nxt_open[b] = bank_open[b];
      if (act_go && sdram_ba == 2'(b))
        nxt_open[b] = 1'b1;
      if (is_pre && (sdram_addr[10] || sdram_ba == 2'(b)))
        nxt_open[b] = 1'b0;
      if (ap_close && beat_ba == 2'(b))
        nxt_open[b] = 1'b0;
    end
  end

  always_comb begin
    any_open = |bank_open;
    tgt_open = bank_open[sdram_ba];
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      mode_ok   <= 1'b0;
      mode_cl3  <= 1'b0;
      mode_bl   <= 2'd0;
      for (int b = 0; b < 4; b++) bank_row[b] <= '0;
      proto_err <= 1'b0;
      err_code  <= 3'd0;
      b_act     <= 1'b0;
      b_wr      <= 1'b0;
      b_ap      <= 1'b0;
      b_ba      <= 2'd0;
      b_col     <= '0;
      b_k       <= 3'd0;
      s0_v      <= 1'b0;
      s0_d      <= 16'd0;
      s1_v      <= 1'b0;
      s1_d      <= 16'd0;
      o_oe      <= 2'b00;
      o_d       <= 16'd0;
      dqm_d     <= 2'b00;
    end else if (sdram_cke) begin
      dqm_d <= sdram_dqm;
      if (lmr_go) begin
        mode_ok  <= 1'b1;
        mode_cl3 <= sdram_addr[4];
        mode_bl  <= sdram_addr[1:0];
      end
      if (act_go) bank_row[sdram_ba] <= sdram_addr[ROW_W-1:0];
      if (err != 3'd0) begin
        proto_err <= 1'b1;
        if (!proto_err) err_code <= err;
      end
      if (rw_go) begin
        b_act <= blm1 != 3'd0;
        b_k   <= 3'd1;
        b_wr  <= is_wr;
        b_ap  <= sdram_addr[10];
        b_ba  <= sdram_ba;
        b_col <= sdram_addr[COL_W-1:0];
      end else if (cont) begin
        b_k <= b_k + 3'd1;
        if (beat_last) b_act <= 1'b0;
      end else begin
        b_act <= 1'b0;
      end
      s0_v <= beat_en & ~beat_wr;
      s0_d <= mem[beat_addr];
      // A write takes the bus back at once: drop any read data in flight.
      if (rw_go && is_wr) begin
        s1_v <= 1'b0;
        o_oe <= 2'b00;
      end else begin
        s1_v <= s0_v;
        s1_d <= s0_d;
        o_oe <= (mode_cl3 ? s1_v : s0_v) ? ~dqm_d : 2'b00;
        o_d  <= mode_cl3 ? s1_d : s0_d;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (sdram_cke && beat_en && beat_wr) begin
      if (!sdram_dqm[0]) mem[beat_addr][7:0]  <= sdram_dq[7:0];
      if (!sdram_dqm[1]) mem[beat_addr][15:8] <= sdram_dq[15:8];
    end
  end

`ifdef SDRAM_RESP_TIMING_CHECK_EN
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int b = 0; b < 4; b++) tmr[b] <= 8'd0;
    end else if (sdram_cke) begin
      for (int b = 0; b < 4; b++) begin
        if (act_go && sdram_ba == 2'(b))
          tmr[b] <= 8'(TRCD - 1);
        else if ((is_pre && (sdram_addr[10] || sdram_ba == 2'(b))) ||
                 (ap_close && beat_ba == 2'(b)))
          tmr[b] <= 8'(TRP - 1);
        else if (tmr[b] != 8'd0)
          tmr[b] <= tmr[b] - 8'd1;
      end
    end
  end
`endif

  assign sdram_dq[7:0]  = o_oe[0] ? o_d[7:0]  : 8'bz;
  assign sdram_dq[15:8] = o_oe[1] ? o_d[15:8] : 8'bz;

endmodule

// File: tb/tb_sdram_chip_responder.sv
// Bench for sdram_chip_responder: directed and randomized bursts
// compared against a behavioural memory/bank model.
module tb_sdram_chip_responder;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_LMR = 3'b000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] addr;
  logic [1:0] ba, dqm;
  logic cs_n, ras_n, cas_n, we_n, cke;
  wire [15:0] dq;
  logic [15:0] dq_drv;
  logic dq_oe;
  logic proto_err;
  logic [2:0] err_code;

  assign dq = dq_oe ? dq_drv : 16'bz;
  // Undriven lanes read as 1, so a released bus reads 16'hFFFF.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup pu (dq[i]);
  end

  always #5 clk = ~clk;

  sdram_chip_responder dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .sdram_addr  (addr),
    .sdram_ba    (ba),
    .sdram_cs_n  (cs_n),
    .sdram_ras_n (ras_n),
    .sdram_cas_n (cas_n),
    .sdram_we_n  (we_n),
    .sdram_cke   (cke),
    .sdram_dqm   (dqm),
    .sdram_dq    (dq),
    .proto_err   (proto_err),
    .err_code    (err_code)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] mdl [1024];
  int brow [4];
  int cur_cl, cur_bl;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] b,
                       input logic [11:0] a);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
    tick();
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP;
  endtask

  function automatic int idx(input int b, input int r, input int c);
    return b * 256 + (r % 16) * 16 + (c % 16);
  endfunction

  function automatic int bcol(input int start, input int k);
    int base;
    base = start - (start % cur_bl);
    return base + ((start % cur_bl) + k) % cur_bl;
  endfunction

  task automatic init_mode(input int cl, input int blc);
    issue(C_PRE, 2'd0, 12'h400);
    issue(C_LMR, 2'd0, 12'(cl * 16 + blc));
    cur_cl = cl;
    cur_bl = 1 << blc;
  endtask

  task automatic open_row(input int b, input int r);
    issue(C_ACT, 2'(b), 12'(r));
    brow[b] = r;
    tick();
  endtask

  task automatic write_burst(input int b, input int c,
                             input logic [15:0] d [8],
                             input logic [1:0] m [8]);
    int i;
    for (int k = 0; k < cur_bl; k++) begin
      dq_drv = d[k];
      dq_oe = 1'b1;
      dqm = m[k];
      if (k == 0) issue(C_WR, 2'(b), 12'(c));
      else tick();
      i = idx(b, brow[b], bcol(c, k));
      if (!m[k][0]) mdl[i][7:0] = d[k][7:0];
      if (!m[k][1]) mdl[i][15:8] = d[k][15:8];
    end
    dq_oe = 1'b0;
    dqm = 2'b00;
  endtask

  task automatic read_check(input string tag, input int b, input int c,
                            input bit ap, input logic [1:0] rm [12]);
    int k;
    logic [15:0] e;
    logic [1:0] mk;
    dqm = rm[0];
    issue(C_RD, 2'(b), 12'(c) | (ap ? 12'h400 : 12'h000));
    for (int j = 1; j <= cur_cl - 1 + cur_bl; j++) begin
      dqm = rm[j];
      tick();
      k = j - cur_cl + 1;
      if (k >= 0 && k < cur_bl) begin
        e = mdl[idx(b, brow[b], bcol(c, k))];
        mk = rm[cur_cl + k - 2];
        if (mk[0]) e[7:0] = 8'hFF;
        if (mk[1]) e[15:8] = 8'hFF;
        check($sformatf("%s beat%0d", tag, k), dq, e);
      end else begin
        check($sformatf("%s idle j%0d", tag, j), dq, 16'hFFFF);
      end
    end
    dqm = 2'b00;
  endtask

  initial begin
    logic [15:0] d [8];
    logic [1:0] m [8];
    logic [1:0] m0 [8];
    logic [1:0] rm [12];
    logic [1:0] rm0 [12];
    int b, r, c, c2, c3;

    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP;
    cke = 1'b1;
    addr = '0;
    ba = '0;
    dqm = '0;
    dq_oe = 1'b0;
    dq_drv = '0;
    for (int k = 0; k < 8; k++) m0[k] = 2'b00;
    for (int j = 0; j < 12; j++) rm0[j] = 2'b00;

    repeat (2) tick();
    check("reset dq", dq, 16'hFFFF);
    check("reset proto_err", 16'(proto_err), 16'd0);
    check("reset err_code", 16'(err_code), 16'd0);
    rst = 1'b0;
    tick();

    // CL=2 BL=1 single write and read
    init_mode(2, 0);
    open_row(1, 3);
    d[0] = 16'hA5C3;
    write_burst(1, 5, d, m0);
    tick();
    issue(C_RD, 2'd1, 12'd5);
    tick();
    check("cl2 beat", dq, 16'hA5C3);
    tick();
    check("cl2 release", dq, 16'hFFFF);
    check("cl2 proto_err", 16'(proto_err), 16'd0);

    // CL=3 BL=4 wrapping burst
    init_mode(3, 2);
    open_row(0, 5);
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333; d[3] = 16'h4444;
    write_burst(0, 6, d, m0);
    read_check("cl3bl4", 0, 6, 1'b0, rm0);
    check("cl3 col4", mdl[idx(0, 5, 4)], 16'h3333);

    // byte masks on write and on read
    init_mode(2, 0);
    open_row(2, 1);
    d[0] = 16'h0000;
    write_burst(2, 0, d, m0);
    d[0] = 16'hBEEF;
    m[0] = 2'b10;
    write_burst(2, 0, d, m);
    read_check("dqm write", 2, 0, 1'b0, rm0);
    for (int j = 0; j < 12; j++) rm[j] = 2'b01;
    read_check("dqm read", 2, 0, 1'b0, rm);

    // randomized modes, bursts, masks
    for (int it = 0; it < 40; it++) begin
      init_mode($urandom_range(2, 3), $urandom_range(0, 3));
      b = $urandom_range(0, 3);
      r = $urandom_range(0, 15);
      open_row(b, r);
      c = $urandom_range(0, 15);
      for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
      write_burst(b, c, d, m0);
      for (int k = 0; k < 8; k++) begin
        d[k] = 16'($urandom);
        m[k] = 2'($urandom_range(0, 3));
      end
      c2 = c - (c % cur_bl) + $urandom_range(0, cur_bl - 1);
      write_burst(b, c2, d, m);
      for (int j = 0; j < 12; j++) rm[j] = 2'($urandom_range(0, 3));
      c3 = c - (c % cur_bl) + $urandom_range(0, cur_bl - 1);
      read_check($sformatf("rand%0d", it), b, c3,
                 1'($urandom_range(0, 1)), rm);
      check("rand proto_err", 16'(proto_err), 16'd0);
    end

    // reset during a BL=8 read
    init_mode(2, 3);
    open_row(1, 7);
    for (int k = 0; k < 8; k++) d[k] = 16'h1000 + 16'(k) * 16'h0123;
    write_burst(1, 0, d, m0);
    issue(C_RD, 2'd1, 12'd0);
    for (int j = 1; j <= 3; j++) begin
      tick();
      check($sformatf("pre-reset beat%0d", j - 1), dq,
            mdl[idx(1, 7, j - 1)]);
    end
    rst = 1'b1;
    #1;
    check("reset mid-burst dq", dq, 16'hFFFF);
    tick();
    rst = 1'b0;
    tick();
    check("post-reset dq", dq, 16'hFFFF);
    issue(C_LMR, 2'd0, 12'h023);
    cur_cl = 2;
    cur_bl = 8;
    check("lmr after reset", 16'(proto_err), 16'd0);
    open_row(1, 7);
    read_check("after reset", 1, 3, 1'b0, rm0);

    // READ one cycle after ACTIVE
    init_mode(2, 0);
    open_row(3, 2);
    d[0] = 16'h1234;
    write_burst(3, 9, d, m0);
    issue(C_PRE, 2'd0, 12'h400);
    tick();
    issue(C_ACT, 2'd3, 12'd2);
    issue(C_RD, 2'd3, 12'd9);
    tick();
`ifdef SDRAM_RESP_TIMING_CHECK_EN
    check("trcd dq", dq, 16'hFFFF);
    check("trcd proto_err", 16'(proto_err), 16'd1);
    check("trcd err_code", 16'(err_code), 16'd6);
`else
    check("trcd dq", dq, 16'h1234);
    check("trcd proto_err", 16'(proto_err), 16'd0);
`endif
    tick();
    check("trcd release", dq, 16'hFFFF);

    // protocol errors: first code sticks
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    init_mode(2, 0);
    issue(C_RD, 2'd2, 12'd0);
    check("idle read proto_err", 16'(proto_err), 16'd1);
    check("idle read err_code", 16'(err_code), 16'd1);
    tick();
    check("idle read dq0", dq, 16'hFFFF);
    tick();
    check("idle read dq1", dq, 16'hFFFF);
    open_row(0, 1);
    issue(C_ACT, 2'd0, 12'd1);
    check("double act proto_err", 16'(proto_err), 16'd1);
    check("double act err_code", 16'(err_code), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
